// File: rtl/wb_regfile.sv
// Write-back register file: one write port, two combinational read ports with same-cycle
// write-to-read bypass, and a post-reset sequencer that zeroes every entry before rf_ready.
module wb_regfile #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NREG = 32
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic [AW-1:0] wb_i_waddr,
    input  logic          wb_i_wreg,
    input  logic [DW-1:0] wb_i_wdata,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic          re2,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2,
    output logic          rf_ready
);

    typedef enum logic {StInit, StRun} state_e;

    state_e        state_q;
    logic [AW-1:0] clr_cnt_q;
    logic          rf_ready_q;
    logic [DW-1:0] mem_q [NREG];

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q    <= StInit;
            clr_cnt_q  <= '0;
            rf_ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    // Write port is ignored while the clear sweep runs.
                    mem_q[clr_cnt_q] <= '0;
                    clr_cnt_q        <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == AW'(NREG - 1)) begin
                        state_q    <= StRun;
                        rf_ready_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (wb_i_wreg && (wb_i_waddr != '0)) begin
                        mem_q[wb_i_waddr] <= wb_i_wdata;
                    end
                end
                default: begin
                    state_q    <= StInit;
                    clr_cnt_q  <= '0;
                    rf_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Register 0 and idle ports read zero before the bypass is considered.
    always_comb begin
        rdata1 = mem_q[raddr1];
        if (!rf_ready_q || !re1 || (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (wb_i_wreg && (wb_i_waddr == raddr1)) begin
            rdata1 = wb_i_wdata;
        end
    end

    always_comb begin
        rdata2 = mem_q[raddr2];
        if (!rf_ready_q || !re2 || (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (wb_i_wreg && (wb_i_waddr == raddr2)) begin
            rdata2 = wb_i_wdata;
        end
    end

    assign rf_ready = rf_ready_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed scenarios followed by randomized traffic, checked
// against a cycle-level behavioural model of the register file.
module tb_wb_regfile;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    logic          clk = 1'b0;
    logic          rst_;
    logic [AW-1:0] wb_i_waddr;
    logic          wb_i_wreg;
    logic [DW-1:0] wb_i_wdata;
    logic          re1;
    logic [AW-1:0] raddr1;
    logic [DW-1:0] rdata1;
    logic          re2;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata2;
    logic          rf_ready;

    wb_regfile #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .wb_i_waddr(wb_i_waddr),
        .wb_i_wreg (wb_i_wreg),
        .wb_i_wdata(wb_i_wdata),
        .re1       (re1),
        .raddr1    (raddr1),
        .rdata1    (rdata1),
        .re2       (re2),
        .raddr2    (raddr2),
        .rdata2    (rdata2),
        .rf_ready  (rf_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic          rdy;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: ready flag, cycles left in the clear sweep, and register contents.
    logic          m_ready;
    int            m_init_left;
    logic [DW-1:0] m_mem [NREG];

    function automatic logic [DW-1:0] model_read(input logic re, input logic [AW-1:0] ra,
                                                 input logic wreg, input logic [AW-1:0] wa,
                                                 input logic [DW-1:0] wd);
        if (!m_ready || !re || ra == 0) return '0;
        if (wreg && wa == ra) return wd;
        return m_mem[ra];
    endfunction

    task automatic drive(input logic rst, input logic wreg, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic r1, input logic [AW-1:0] a1,
                         input logic r2, input logic [AW-1:0] a2, input string tag);
        exp_t e;
        rst_       = rst;
        wb_i_wreg  = wreg;
        wb_i_waddr = wa;
        wb_i_wdata = wd;
        re1        = r1;
        raddr1     = a1;
        re2        = r2;
        raddr2     = a2;
        e.tag = tag;
        e.rd1 = model_read(r1, a1, wreg, wa, wd);
        e.rd2 = model_read(r2, a2, wreg, wa, wd);
        e.rdy = m_ready;
        sb_q.push_back(e);
        // Advance the model across the coming edge.
        if (rst) begin
            m_ready     = 1'b0;
            m_init_left = NREG;
        end else if (!m_ready) begin
            m_init_left--;
            if (m_init_left == 0) begin
                m_ready = 1'b1;
                for (int i = 0; i < NREG; i++) m_mem[i] = '0;
            end
        end else if (wreg && wa != 0) begin
            m_mem[wa] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, tag);
    endtask

    // Monitor: compare every expectation pushed this cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++;
                if (rf_ready !== e.rdy) begin
                    errors++;
                    $display("FAIL %s rf_ready: got %b expected %b", e.tag, rf_ready, e.rdy);
                end
                checks++;
                if (rdata1 !== e.rd1) begin
                    errors++;
                    $display("FAIL %s rdata1: got %h expected %h", e.tag, rdata1, e.rd1);
                end
                checks++;
                if (rdata2 !== e.rd2) begin
                    errors++;
                    $display("FAIL %s rdata2: got %h expected %h", e.tag, rdata2, e.rd2);
                end
            end
        end
    end

    initial begin
        logic          rst_r, wreg_r, r1_r, r2_r;
        logic [AW-1:0] wa_r, a1_r, a2_r;
        logic [DW-1:0] wd_r;

        rst_ = 1'b1; wb_i_wreg = 1'b0; wb_i_waddr = '0; wb_i_wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        m_ready = 1'b0; m_init_left = NREG;
        for (int i = 0; i < NREG; i++) m_mem[i] = '1;
        @(posedge clk);
        #1;

        // 1: second reset cycle, then sweep reads across the clear sequence and beyond
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, "reset");
        for (int i = 0; i < 40; i++)
            drive(1'b0, 1'b0, '0, '0, 1'b1, AW'((i % 31) + 1), 1'b1, AW'(31 - (i % 31)), "init");

        // 2: write then read back, then read disabled
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, '0, "wr_r5");
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 1'b0, '0, "rd_r5");
        drive(1'b0, 1'b0, '0, '0, 1'b0, 5'd5, 1'b0, '0, "rd_r5_re0");

        // 3: bypass on port 2, then from storage
        drive(1'b0, 1'b1, 5'd7, 32'h1234, 1'b0, '0, 1'b1, 5'd7, "byp_r7");
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd7, "rd_r7");

        // 4: register 0 ignores writes and never bypasses
        drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, 1'b0, '0, "wr_r0");
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 1'b1, 5'd0, "rd_r0");
        drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0, "byp_r0");

        // 5: reset mid-run, write during the sweep is lost
        drive(1'b0, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, '0, 1'b0, '0, "wr_r9");
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 1'b0, '0, "rd_r9");
        drive(1'b1, 1'b1, 5'd9, 32'h77777777, 1'b1, 5'd9, 1'b0, '0, "rst_mid");
        idle(5, "init2");
        drive(1'b0, 1'b1, 5'd9, 32'h55555555, 1'b1, 5'd9, 1'b1, 5'd9, "wr_in_init");
        for (int i = 0; i < 30; i++) drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 1'b1, 5'd5, "init2b");

        // 6: back-to-back writes to the same register tracked through the bypass
        drive(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 1'b0, '0, "b2b_11");
        drive(1'b0, 1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 1'b1, 5'd3, "b2b_22");
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 1'b1, 5'd3, "b2b_rd");

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst_r  = ($urandom_range(0, 399) == 0);
            wreg_r = 1'($urandom_range(0, 1));
            wa_r   = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7))
                                                 : AW'($urandom_range(0, 31));
            wd_r   = $urandom;
            r1_r   = ($urandom_range(0, 7) != 0);
            r2_r   = ($urandom_range(0, 7) != 0);
            a1_r   = ($urandom_range(0, 3) == 0) ? wa_r : AW'($urandom_range(0, 7));
            a2_r   = ($urandom_range(0, 3) == 0) ? wa_r : AW'($urandom_range(0, 31));
            drive(rst_r, wreg_r, wa_r, wd_r, r1_r, a1_r, r2_r, a2_r, "rand");
        end

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
